read_mem: RTL and testbench
===========================

Name: read_mem

Overview:
Readout side of the analyzer's circular sample buffer; the counterpart to the capture writer.
- On a start pulse, streams every valid stored sample out, oldest first, over a valid/ready interface. Feeds the host/UART dump path.
- Drives the buffer's synchronous read port.
- Takes the writer's write pointer and primed flag to locate the oldest sample and the sample count.

Parameters:
DATA_WIDTH, 8, sample width in bits
ADDR_WIDTH, 4, buffer address width; buffer depth MEMORY_SIZE = 2**ADDR_WIDTH
MEMORY_SIZE, 16, buffer depth; must equal 2**ADDR_WIDTH

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
start  input  1  single-cycle request to begin a readout
waddr  input  ADDR_WIDTH  writer's next write address, sampled only at accepted start
primed  input  1  writer flag: every buffer location written at least once; sampled only at accepted start
raddr  output  ADDR_WIDTH  buffer read address (registered)
rdata  input  DATA_WIDTH  buffer read data; equals memory[raddr] one cycle after raddr is presented
out_data  output  DATA_WIDTH  sample being offered downstream
out_valid  output  1  out_data holds a valid sample
out_ready  input  1  downstream accepts; a transfer occurs on a rising edge with out_valid & out_ready
busy  output  1  readout in progress (state != IDLE)
done  output  1  one-cycle pulse marking the end of a readout

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - raddr=0, out_data=0, out_valid=0, busy=0, done=0.
  - Remaining-count register = 0.
  - Reset asserted mid-readout aborts it; no done pulse is produced.
- States: IDLE, FETCH, WAIT, PRESENT, DONE.
- IDLE:
  - start=1 is accepted.
  - Base address = primed ? waddr : 0.
  - Remaining count (ADDR_WIDTH+1 bits) = primed ? MEMORY_SIZE : {1'b0,waddr}.
  - If the count is 0, go to DONE. Otherwise raddr<=base and go to FETCH.
- FETCH: raddr is stable for one cycle; go to WAIT.
- WAIT: rdata is valid. out_data<=rdata, out_valid<=1, go to PRESENT.
- PRESENT:
  - out_data is held stable while out_ready=0; there is no timeout.
  - On transfer: out_valid<=0 and remaining is decremented.
  - If remaining was 1, go to DONE.
  - Otherwise raddr<=raddr+1, wrapping modulo 2**ADDR_WIDTH (MEMORY_SIZE-1 -> 0), and go to FETCH.
- DONE: done=1 for exactly one cycle; return to IDLE.
- Latency:
  - start accepted at edge E0 -> raddr=base after E0 -> out_valid=1 after E0+2.
  - With out_ready held high, one sample is transferred every 3 cycles.
- start while busy (any state other than IDLE) is ignored; it is neither queued nor restarts the readout.
- waddr and primed are ignored except at the accepting edge. Capture must be stopped (write_enable=0) before start.
  - If writes continue during readout, the data returned is the buffer contents at read time.
  - Sample count and order are still as latched at start, and the FSM still terminates.
- Width rules:
  - The count register is ADDR_WIDTH+1 bits so it can hold MEMORY_SIZE.
  - raddr increment is ADDR_WIDTH bits, natural wrap.
- busy=1 in FETCH, WAIT, PRESENT and DONE; busy=0 only in IDLE.

Test Plan:
1. Unprimed, memory[i]=i+10, waddr=5; start pulse with out_ready=1 -> samples 10,11,12,13,14 transferred in order. First out_valid appears 3 cycles after start. done pulses once, 1 cycle after the 5th transfer; busy then drops.
2. Primed, waddr=3, ADDR_WIDTH=4, memory[i]=i -> 16 samples: 3..15, then 0,1,2. raddr wraps 15->0. done follows the 16th transfer.
3. Unprimed, waddr=0; start -> out_valid never rises. done=1 in the cycle after start; busy is high for that cycle only.
4. Backpressure in case 1: hold out_ready=0 for 4 cycles while the 2nd sample is valid -> out_data=11 is stable and raddr does not advance. Output resumes at 12 after out_ready=1.
5. start pulse during PRESENT of case 2 -> ignored; output is still exactly 16 samples with a single done pulse.
6. Reset asserted mid-readout, between clock edges -> out_valid and busy go to 0 immediately with no done pulse. A later start performs a full, correct readout.

Source files
------------

// File: rtl/read_mem.sv
// read_mem: streams every valid sample of the circular capture buffer out, oldest first, over valid/ready.
module read_mem #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int MEMORY_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  primed,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PRESENT, DONE} state_t;
  localparam logic [ADDR_WIDTH:0] full_count = (ADDR_WIDTH+1)'(MEMORY_SIZE);
  state_t                  state, state_n;
  logic [ADDR_WIDTH:0]     remaining, remaining_n;
  logic [ADDR_WIDTH-1:0]   raddr_n;
  logic [DATA_WIDTH-1:0]   out_data_n;
  logic                    out_valid_n;
  logic                    xfer;
  assign xfer = out_valid & out_ready;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_n     = state;
    raddr_n     = raddr;
    remaining_n = remaining;
    out_data_n  = out_data;
    out_valid_n = out_valid;
    case (state)
      IDLE: if (start) begin
        remaining_n = primed ? full_count : {1'b0, waddr};
        raddr_n     = primed ? waddr : '0;
        state_n     = (!primed && waddr == '0) ? DONE : FETCH;
      end
      FETCH: state_n = WAIT;
      WAIT: begin
        out_data_n  = rdata;
        out_valid_n = 1'b1;
        state_n     = PRESENT;
      end
      PRESENT: if (xfer) begin
        out_valid_n = 1'b0;
        remaining_n = remaining - 1'b1;
        raddr_n     = (remaining == 1) ? raddr : raddr + 1'b1;
        state_n     = (remaining == 1) ? DONE : FETCH;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      raddr     <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      raddr     <= raddr_n;
      remaining <= remaining_n;
      out_data  <= out_data_n;
      out_valid <= out_valid_n;
    end
  end
endmodule

// File: tb/tb_read_mem.sv
// tb_read_mem: table, random and hand-written sequences for read_mem against a queue-based readout model.
module tb_read_mem;
  localparam int DW = 8, AW = 4, MS = 16;
  logic clk = 0, reset, start, primed, out_ready, out_valid, busy, done;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] rdata, out_data;
  logic [DW-1:0] mem [MS];
  logic ready_fix, ready_rnd = 1;
  bit rmode;
  int asserts = 0, failures = 0, dones = 0;
  logic [DW-1:0] got[$];

  typedef struct {bit p; logic [AW-1:0] w; int n; int first; int last;} vec_t;
  vec_t vecs[7];

  read_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEMORY_SIZE(MS)) dut (
    .clk(clk), .reset(reset), .start(start), .waddr(waddr), .primed(primed),
    .raddr(raddr), .rdata(rdata), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rdata <= mem[raddr];
  always @(posedge clk) begin
    #2;
    ready_rnd = 1'($urandom_range(0, 1));
  end
  assign out_ready = rmode ? ready_rnd : ready_fix;

  always @(negedge clk) begin
    if (out_valid && out_ready) got.push_back(out_data);
    if (done) dones++;
  end

  task automatic check(string name, int act, int expv);
    asserts++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_start(bit p, logic [AW-1:0] w);
    primed = p;
    waddr  = w;
    start  = 1;
    tick();
    start  = 0;
    primed = 1'($urandom);
    waddr  = AW'($urandom);
  endtask

  task automatic fill_offset(int off);
    for (int i = 0; i < MS; i++) mem[i] = DW'(i + off);
  endtask

  task automatic wait_idle(string tag, int budget);
    int c = 0;
    while (busy && c < budget) begin
      tick();
      c++;
    end
    check({tag, " timeout"}, int'(c < budget), 1);
  endtask

  task automatic run_check(string tag, bit p, logic [AW-1:0] w, int budget);
    logic [DW-1:0] e[$];
    int n, base, mism;
    n = p ? MS : int'(w);
    base = p ? int'(w) : 0;
    for (int i = 0; i < n; i++) e.push_back(mem[(base + i) % MS]);
    got.delete();
    dones = 0;
    pulse_start(p, w);
    wait_idle(tag, budget);
    check({tag, " count"}, got.size(), e.size());
    mism = 0;
    for (int i = 0; i < got.size() && i < e.size(); i++) if (got[i] !== e[i]) mism++;
    check({tag, " data mismatches"}, mism, 0);
    check({tag, " done pulses"}, dones, 1);
  endtask

  initial begin
    vecs[0] = '{0, 4'd5,  5,  10, 14};
    vecs[1] = '{1, 4'd3,  16, 13, 12};
    vecs[2] = '{0, 4'd0,  0,  -1, -1};
    vecs[3] = '{1, 4'd0,  16, 10, 25};
    vecs[4] = '{0, 4'd15, 15, 10, 24};
    vecs[5] = '{1, 4'd15, 16, 25, 24};
    vecs[6] = '{0, 4'd1,  1,  10, 10};
    start = 0; primed = 0; waddr = 0; ready_fix = 1; rmode = 0; reset = 0;
    fill_offset(10);
    #1 reset = 1;
    #2;
    check("reset raddr", int'(raddr), 0);
    check("reset out_data", int'(out_data), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    tick(2);
    reset = 0;
    tick();

    foreach (vecs[k]) begin
      run_check($sformatf("vec%0d", k), vecs[k].p, vecs[k].w, 200);
      if (vecs[k].n > 0) begin
        check($sformatf("vec%0d first", k), int'(got[0]), vecs[k].first);
        check($sformatf("vec%0d last", k), int'(got[got.size() - 1]), vecs[k].last);
      end
    end

    // latency, backpressure and done timing on the 5-sample unprimed readout
    fill_offset(10);
    got.delete(); dones = 0; ready_fix = 1;
    pulse_start(0, 4'd5);
    check("lat busy", int'(busy), 1);
    check("lat raddr base", int'(raddr), 0);
    check("lat valid E0", int'(out_valid), 0);
    tick();
    check("lat valid E1", int'(out_valid), 0);
    tick();
    check("lat valid E2", int'(out_valid), 1);
    check("lat first data", int'(out_data), 10);
    tick();
    check("bp raddr after xfer", int'(raddr), 1);
    check("bp valid after xfer", int'(out_valid), 0);
    ready_fix = 0;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      check("bp hold valid", int'(out_valid), 1);
      check("bp hold data", int'(out_data), 11);
      check("bp hold raddr", int'(raddr), 1);
      tick();
    end
    ready_fix = 1;
    begin
      int c = 0;
      while (got.size() < 5 && c < 100) begin
        tick();
        c++;
      end
      check("bp xfer budget", int'(c < 100), 1);
    end
    check("end done high", int'(done), 1);
    check("end busy high", int'(busy), 1);
    tick();
    check("end done low", int'(done), 0);
    check("end busy low", int'(busy), 0);
    check("bp count", got.size(), 5);
    for (int i = 0; i < got.size(); i++) check("bp order", int'(got[i]), 10 + i);
    check("bp done pulses", dones, 1);

    // empty buffer: straight to DONE for one cycle
    dones = 0; got.delete();
    pulse_start(0, 4'd0);
    check("empty done", int'(done), 1);
    check("empty busy", int'(busy), 1);
    check("empty valid", int'(out_valid), 0);
    tick();
    check("empty done drop", int'(done), 0);
    check("empty busy drop", int'(busy), 0);
    check("empty xfers", got.size(), 0);
    check("empty done pulses", dones, 1);

    // start during PRESENT is ignored
    fill_offset(0);
    got.delete(); dones = 0; ready_fix = 0;
    pulse_start(1, 4'd3);
    tick(2);
    check("ign in present", int'(out_valid), 1);
    pulse_start(0, 4'd9);
    ready_fix = 1;
    wait_idle("ign", 200);
    check("ign count", got.size(), 16);
    for (int i = 0; i < got.size(); i++) check("ign order", int'(got[i]), (3 + i) % 16);
    check("ign done pulses", dones, 1);

    // asynchronous reset mid-readout
    fill_offset(10);
    got.delete(); dones = 0;
    pulse_start(1, 4'd7);
    tick(4);
    #1 reset = 1;
    #1;
    check("arst valid", int'(out_valid), 0);
    check("arst busy", int'(busy), 0);
    check("arst raddr", int'(raddr), 0);
    tick();
    reset = 0;
    tick(3);
    check("arst no done", dones, 0);
    check("arst idle", int'(busy), 0);
    run_check("after reset", 1, 4'd7, 200);

    // randomized readouts with random backpressure
    rmode = 1;
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < MS; i++) mem[i] = DW'($urandom);
      run_check($sformatf("rnd%0d", r), 1'($urandom), AW'($urandom), 600);
    end
    rmode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule
